bootloader_ctrl: RTL and testbench
==================================

BOOTLOADER_CTRL -- requirements
Module: bootloader_ctrl

Interface
REQ-001 Parameter MAX_WORDS, default 8001: maximum image length in 32-bit words, equal to the instruction-memory depth.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: maximum idle cycles allowed between received bytes during a load.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rx_data  in  8  byte from the UART receiver.
REQ-006 rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-007 tx_data  out  8  response byte to the UART transmitter.
REQ-008 tx_start  out  1  one-cycle strobe launching tx_data.
REQ-009 tx_busy  in  1  transmitter busy; tx_start is forbidden while high.
REQ-010 MEM_we  out  1  instruction-memory write enable.
REQ-011 MEM_Waddr  out  32  word index (not byte address) for both write and readback.
REQ-012 MEM_Wdata  out  32  instruction-memory write data.
REQ-013 MemRead  out  1  readback enable; memory returns MEM[MEM_Waddr] combinationally on bl_dout.
REQ-014 bl_dout  in  32  readback data from instruction memory.
REQ-015 cpu_hold  out  1  holds the CPU in reset while high.
REQ-016 bl_done  out  1  image loaded and verified; sticky.
REQ-017 bl_error  out  1  last load failed; sticky until the next sync byte.

Function
REQ-018 The FSM SHALL use states IDLE, CNT_LO, CNT_HI, DATA, CSUM, VERIFY, CHECK, RESP, DONE and ERR.
REQ-019 In IDLE, the FSM SHALL ignore every byte except 0xA5; on 0xA5 -> CNT_LO, clearing the word index, byte index and 8-bit sum, and clearing bl_error.
REQ-020 In CNT_LO and CNT_HI, the FSM SHALL capture a 16-bit word count, little-endian (low byte first).
REQ-021 After CNT_HI: count > MAX_WORDS -> ERR; count == 0 -> CSUM; otherwise -> DATA.
REQ-022 In DATA, the block SHALL assemble bytes little-endian (first byte -> [7:0]) and add each byte to the 8-bit sum, mod 256.
REQ-023 On the cycle after the 4th byte of a word, MEM_we SHALL be high for exactly one cycle, with MEM_Waddr = word index and MEM_Wdata = the assembled word; the word index then increments.
REQ-024 DATA SHALL accept an rx_valid arriving in the MEM_we cycle without loss.
REQ-025 When the 4th byte of word count-1 is accepted, the FSM SHALL go to CSUM; the final MEM_we still fires on the next cycle.
REQ-026 In CSUM, the FSM SHALL latch the next byte as the expected checksum and go to VERIFY; if count == 0, it SHALL go directly to CHECK.
REQ-027 In VERIFY, for i = 0..count-1 at one word per cycle, the block SHALL drive MemRead = 1 and MEM_Waddr = i, sample bl_dout in the same cycle, and add its four bytes into a separate 8-bit readback sum.
REQ-028 VERIFY SHALL last exactly count cycles, then go to CHECK.
REQ-029 In CHECK, the FSM SHALL go to RESP with result OK only if the rx sum, the readback sum and the expected checksum are all equal; otherwise it SHALL go to ERR.
REQ-030 In RESP and ERR, the block SHALL wait while tx_busy = 1, then pulse tx_start for one cycle with tx_data = 0x4B ('K') for OK or 0x45 ('E') for error.
REQ-031 After 'K', the FSM SHALL enter DONE: cpu_hold = 0, bl_done = 1, stay in DONE until reset, and ignore all rx bytes.
REQ-032 After 'E', the FSM SHALL return to IDLE with bl_error = 1 and cpu_hold = 1.
REQ-033 In CNT_LO, CNT_HI, DATA and CSUM, a counter SHALL reload on each rx_valid; reaching TIMEOUT_CYCLES consecutive cycles without rx_valid SHALL force ERR.
REQ-034 MEM_we and MemRead SHALL never be high in the same cycle.
REQ-035 MEM_we SHALL never be asserted outside DATA or its trailing cycle.
REQ-036 Outputs SHALL be registered, except MemRead/MEM_Waddr in VERIFY, which may be decoded from state and index.

Reset
REQ-037 While reset = 1, the block SHALL hold: state = IDLE, cpu_hold = 1, and all other outputs = 0 (tx_start, MEM_we, MemRead, MEM_Waddr, MEM_Wdata, tx_data, bl_done, bl_error).
REQ-038 Reset asserted mid-load SHALL take effect on the next clock edge, with no further MEM_we; memory contents already written are left unchanged.

Verification
REQ-039 Good load: A5 02 00 13 00 00 00 93 00 10 00 B6 -> MEM_we at addr 0 with 0x00000013, then addr 1 with 0x00100093; 2 MemRead cycles returning those words; tx 0x4B; cpu_hold 1->0; bl_done = 1.
REQ-040 Bad checksum: same stream with last byte 0x00 -> tx 0x45, bl_error = 1, cpu_hold = 1, state IDLE; a subsequent good load succeeds and clears bl_error.
REQ-041 Oversize: A5 42 1F (count 8002) -> ERR immediately, no MEM_we, tx 0x45.
REQ-042 Timeout (TIMEOUT_CYCLES = 100): A5 01 00 13 00 then silence -> ERR exactly 100 cycles after the last rx_valid, no MEM_we.
REQ-043 Empty image: A5 00 00 00 -> no MEM_we, no MemRead, tx 0x4B, bl_done = 1.
REQ-044 tx_busy held high 50 cycles at RESP -> tx_start is delayed until the first cycle after tx_busy falls; reset asserted mid-DATA -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/bootloader_ctrl_if.sv
// Bootloader-side bundle: UART byte stream, instruction-memory port and CPU status lines.
interface bootloader_ctrl_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        MEM_we;
    logic [31:0] MEM_Waddr;
    logic [31:0] MEM_Wdata;
    logic        MemRead;
    logic [31:0] bl_dout;
    logic        cpu_hold;
    logic        bl_done;
    logic        bl_error;

    modport master (
        input  rx_data, rx_valid, tx_busy, bl_dout,
        output tx_data, tx_start, MEM_we, MEM_Waddr, MEM_Wdata, MemRead,
               cpu_hold, bl_done, bl_error
    );

    modport slave (
        output rx_data, rx_valid, tx_busy, bl_dout,
        input  tx_data, tx_start, MEM_we, MEM_Waddr, MEM_Wdata, MemRead,
               cpu_hold, bl_done, bl_error
    );
endinterface

// File: rtl/bootloader_ctrl.sv
// UART bootloader: receives a length-prefixed image, writes it into instruction
// memory, reads it back to verify the checksum, then releases the CPU.
//
// state  | meaning
// IDLE   | waiting for the 0xA5 sync byte
// CNT_LO | receiving word-count low byte
// CNT_HI | receiving word-count high byte, range check
// DATA   | assembling little-endian words and writing them
// CSUM   | receiving the expected checksum byte
// VERIFY | reading back one word per cycle into the readback sum
// CHECK  | comparing rx sum, readback sum and expected checksum
// RESP   | sending 'K' once the transmitter is free
// DONE   | image accepted, CPU released, all input ignored
// ERR    | sending 'E' once the transmitter is free, then back to IDLE
module bootloader_ctrl #(
    parameter int MAX_WORDS      = 8001,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    bootloader_ctrl_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, CNT_LO, CNT_HI, DATA, CSUM, VERIFY, CHECK, RESP, DONE, ERR
    } state_t;

    state_t        state, state_nxt;
    logic [15:0]   word_cnt;
    logic [15:0]   wr_idx;
    logic [15:0]   rd_idx;
    logic [1:0]    byte_idx;
    logic [23:0]   word_sr;
    logic [7:0]    rx_sum, rb_sum, exp_sum;
    logic [TW-1:0] tmo_cnt;

    logic [7:0]    tx_data_q;
    logic [31:0]   waddr_q, wdata_q;
    logic          tx_start_q, mem_we_q, cpu_hold_q, bl_done_q, bl_error_q;

    logic [15:0]   cnt_full;
    logic          timed, tmo_hit, last_byte, last_word, rb_last, sums_ok;

    assign cnt_full  = {bus.rx_data, word_cnt[7:0]};
    assign timed     = state inside {CNT_LO, CNT_HI, DATA, CSUM};
    assign tmo_hit   = timed && !bus.rx_valid && (tmo_cnt == '0);
    assign last_byte = (byte_idx == 2'd3);
    assign last_word = (wr_idx == word_cnt - 16'd1);
    assign rb_last   = (rd_idx == word_cnt - 16'd1);
    assign sums_ok   = (rx_sum == rb_sum) && (rb_sum == exp_sum);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode; an expired inter-byte timer overrides everything.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (bus.rx_valid && bus.rx_data == 8'hA5) state_nxt = CNT_LO;
            CNT_LO: if (bus.rx_valid) state_nxt = CNT_HI;
            CNT_HI: begin
                if (bus.rx_valid) begin
                    if (int'(cnt_full) > MAX_WORDS) state_nxt = ERR;
                    else if (cnt_full == 16'd0)      state_nxt = CSUM;
                    else                             state_nxt = DATA;
                end
            end
            DATA:   if (bus.rx_valid && last_byte && last_word) state_nxt = CSUM;
            CSUM:   if (bus.rx_valid) state_nxt = (word_cnt == 16'd0) ? CHECK : VERIFY;
            VERIFY: if (rb_last) state_nxt = CHECK;
            CHECK:  state_nxt = sums_ok ? RESP : ERR;
            RESP:   if (!bus.tx_busy) state_nxt = DONE;
            ERR:    if (!bus.tx_busy) state_nxt = IDLE;
            DONE:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (tmo_hit) state_nxt = ERR;
    end

    // Datapath and registered outputs; the write strobe trails the 4th byte by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt   <= '0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            byte_idx   <= '0;
            word_sr    <= '0;
            rx_sum     <= '0;
            rb_sum     <= '0;
            exp_sum    <= '0;
            tmo_cnt    <= TMO_LOAD;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            mem_we_q   <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            cpu_hold_q <= 1'b1;
            bl_done_q  <= 1'b0;
            bl_error_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            mem_we_q   <= 1'b0;
            if (bus.rx_valid)                   tmo_cnt <= TMO_LOAD;
            else if (timed && tmo_cnt != '0)    tmo_cnt <= tmo_cnt - TW'(1);
            case (state)
                IDLE: begin
                    if (bus.rx_valid && bus.rx_data == 8'hA5) begin
                        wr_idx     <= '0;
                        byte_idx   <= '0;
                        rx_sum     <= '0;
                        rb_sum     <= '0;
                        bl_error_q <= 1'b0;
                    end
                end
                CNT_LO: if (bus.rx_valid) word_cnt <= {8'h00, bus.rx_data};
                CNT_HI: if (bus.rx_valid) word_cnt <= cnt_full;
                DATA: begin
                    if (bus.rx_valid) begin
                        word_sr  <= {bus.rx_data, word_sr[23:8]};
                        rx_sum   <= rx_sum + bus.rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (last_byte) begin
                            mem_we_q <= 1'b1;
                            waddr_q  <= {16'h0000, wr_idx};
                            wdata_q  <= {bus.rx_data, word_sr};
                            wr_idx   <= wr_idx + 16'd1;
                        end
                    end
                end
                CSUM: begin
                    if (bus.rx_valid) begin
                        exp_sum <= bus.rx_data;
                        rd_idx  <= '0;
                    end
                end
                VERIFY: begin
                    rb_sum <= rb_sum + bus.bl_dout[7:0] + bus.bl_dout[15:8]
                                     + bus.bl_dout[23:16] + bus.bl_dout[31:24];
                    rd_idx <= rd_idx + 16'd1;
                end
                RESP: begin
                    if (!bus.tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= 8'h4B;
                        cpu_hold_q <= 1'b0;
                        bl_done_q  <= 1'b1;
                    end
                end
                ERR: begin
                    if (!bus.tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= 8'h45;
                        bl_error_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.MEM_we    = mem_we_q;
    assign bus.MEM_Wdata = wdata_q;
    assign bus.MemRead   = (state == VERIFY);
    assign bus.MEM_Waddr = (state == VERIFY) ? {16'h0000, rd_idx} : waddr_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.bl_done   = bl_done_q;
    assign bus.bl_error  = bl_error_q;
endmodule

// File: tb/tb_bootloader_ctrl.sv
// Self-checking bench for bootloader_ctrl: table of complete load scenarios plus
// hand-written sequences for timeout, transmitter back-pressure, retry and reset.
module tb_bootloader_ctrl;
    logic clk = 1'b0;
    logic reset;
    bit   corrupt;
    bit   clr_req;
    int   n_chk, n_miss;
    int   n_we, n_rd, n_tx, n_overlap, n_txbusy;
    logic [31:0] wlog_addr [8];
    logic [31:0] wlog_data [8];
    logic [31:0] rlog_addr [8];
    logic [31:0] mem [64];
    logic [7:0]  tx_last;

    typedef struct {
        string        name;
        int           nb;
        logic [127:0] stream;
        bit           corrupt;
        logic [7:0]   resp;
        int           n_we;
        int           n_rd;
        logic [31:0]  w0;
        logic [31:0]  w1;
        logic         done;
        logic         err;
        logic         hold;
    } vec_t;

    vec_t vt [7];

    bootloader_ctrl_if bus ();

    bootloader_ctrl #(.MAX_WORDS(8001), .TIMEOUT_CYCLES(100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Instruction memory model; corrupt flips bit 0 of every readback word.
    assign bus.bl_dout = mem[bus.MEM_Waddr[5:0]] ^ {31'd0, corrupt};

    // Monitor: samples mid-cycle, logs writes/reads/responses and protocol violations.
    always @(negedge clk) begin
        if (clr_req) begin
            n_we = 0; n_rd = 0; n_tx = 0; n_overlap = 0; n_txbusy = 0;
            tx_last = 8'h00;
            for (int i = 0; i < 64; i++) mem[i] = '0;
        end else begin
            if (bus.MEM_we) begin
                mem[bus.MEM_Waddr[5:0]] = bus.MEM_Wdata;
                if (n_we < 8) begin
                    wlog_addr[n_we] = bus.MEM_Waddr;
                    wlog_data[n_we] = bus.MEM_Wdata;
                end
                n_we++;
            end
            if (bus.MemRead) begin
                if (n_rd < 8) rlog_addr[n_rd] = bus.MEM_Waddr;
                n_rd++;
            end
            if (bus.MEM_we && bus.MemRead) n_overlap++;
            if (bus.tx_start) begin
                tx_last = bus.tx_data;
                n_tx++;
                if (bus.tx_busy) n_txbusy++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_stats();
        clr_req = 1'b1;
        @(negedge clk); #1;
        clr_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        bus.tx_busy = 1'b0; corrupt = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_valid = 1'b1; bus.rx_data = b;
    endtask

    task automatic release_rx();
        @(posedge clk); #1;
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    endtask

    task automatic send_seq(input logic [127:0] s, input int nb);
        for (int j = 0; j < nb; j++) send(s[8*(nb-1-j) +: 8]);
    endtask

    task automatic wait_tx(input int budget);
        for (int k = 0; k < budget && n_tx == 0; k++) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "/tx_start"},  32'(bus.tx_start),  32'd0);
        chk({tag, "/MEM_we"},    32'(bus.MEM_we),    32'd0);
        chk({tag, "/MemRead"},   32'(bus.MemRead),   32'd0);
        chk({tag, "/MEM_Waddr"}, bus.MEM_Waddr,      32'd0);
        chk({tag, "/MEM_Wdata"}, bus.MEM_Wdata,      32'd0);
        chk({tag, "/tx_data"},   32'(bus.tx_data),   32'd0);
        chk({tag, "/bl_done"},   32'(bus.bl_done),   32'd0);
        chk({tag, "/bl_error"},  32'(bus.bl_error),  32'd0);
        chk({tag, "/cpu_hold"},  32'(bus.cpu_hold),  32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        do_reset();
        corrupt = v.corrupt;
        clear_stats();
        send_seq(v.stream, v.nb);
        release_rx();
        wait_tx(200);
        repeat (3) @(negedge clk);
        chk({v.name, "/tx_count"}, 32'(n_tx), 32'd1);
        chk({v.name, "/tx_data"},  32'(tx_last), 32'(v.resp));
        chk({v.name, "/n_we"},     32'(n_we), 32'(v.n_we));
        chk({v.name, "/n_rd"},     32'(n_rd), 32'(v.n_rd));
        chk({v.name, "/bl_done"},  32'(bus.bl_done),  32'(v.done));
        chk({v.name, "/bl_error"}, 32'(bus.bl_error), 32'(v.err));
        chk({v.name, "/cpu_hold"}, 32'(bus.cpu_hold), 32'(v.hold));
        chk({v.name, "/we_rd_overlap"}, 32'(n_overlap), 32'd0);
        if (v.n_we >= 1) begin
            chk({v.name, "/w0_addr"}, wlog_addr[0], 32'd0);
            chk({v.name, "/w0_data"}, wlog_data[0], v.w0);
        end
        if (v.n_we >= 2) begin
            chk({v.name, "/w1_addr"}, wlog_addr[1], 32'd1);
            chk({v.name, "/w1_data"}, wlog_data[1], v.w1);
        end
        for (int i = 0; i < v.n_rd && i < 8; i++)
            chk($sformatf("%s/rd_addr%0d", v.name, i), rlog_addr[i], 32'(i));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        reset = 1'b1; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        bus.tx_busy = 1'b0; corrupt = 1'b0; clr_req = 1'b0;

        vt[0] = '{"good", 12, 128'hA5_02_00_13_00_00_00_93_00_10_00_B6, 1'b0,
                  8'h4B, 2, 2, 32'h0000_0013, 32'h0010_0093, 1'b1, 1'b0, 1'b0};
        vt[1] = '{"bad_csum", 12, 128'hA5_02_00_13_00_00_00_93_00_10_00_00, 1'b0,
                  8'h45, 2, 2, 32'h0000_0013, 32'h0010_0093, 1'b0, 1'b1, 1'b1};
        vt[2] = '{"oversize", 3, 128'hA5_42_1F, 1'b0,
                  8'h45, 0, 0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1};
        vt[3] = '{"empty", 4, 128'hA5_00_00_00, 1'b0,
                  8'h4B, 0, 0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};
        vt[4] = '{"noise_sync", 11, 128'h00_FF_5A_A5_01_00_01_02_03_04_0A, 1'b0,
                  8'h4B, 1, 1, 32'h0403_0201, 32'h0, 1'b1, 1'b0, 1'b0};
        vt[5] = '{"one_word", 8, 128'hA5_01_00_EF_BE_AD_DE_38, 1'b0,
                  8'h4B, 1, 1, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0, 1'b0};
        vt[6] = '{"rb_corrupt", 12, 128'hA5_02_00_13_00_00_00_93_00_10_00_B6, 1'b1,
                  8'h45, 2, 2, 32'h0000_0013, 32'h0010_0093, 1'b0, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");

        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // Timeout: last byte taken at edge E0; 100 silent cycles move to ERR at E100,
        // and the 'E' strobe is registered one edge later, so it appears after E101.
        do_reset();
        clear_stats();
        send_seq(128'hA5_01_00_13_00, 5);
        release_rx();
        k = 1;
        while (k <= 300) begin
            @(posedge clk); #1;
            if (bus.tx_start) break;
            k++;
        end
        chk("timeout/edges", 32'(k), 32'd101);
        chk("timeout/tx_data", 32'(bus.tx_data), 32'h45);
        @(negedge clk);
        chk("timeout/n_we", 32'(n_we), 32'd0);
        chk("timeout/bl_error", 32'(bus.bl_error), 32'd1);

        // Transmitter busy for 50 cycles while the 'K' is pending.
        do_reset();
        bus.tx_busy = 1'b1;
        clear_stats();
        send_seq(128'hA5_00_00_00, 4);
        release_rx();
        repeat (50) @(posedge clk);
        chk("busy/no_tx_while_busy", 32'(n_tx), 32'd0);
        #1 bus.tx_busy = 1'b0;
        @(negedge clk);
        chk("busy/tx_start_fall_cycle", 32'(bus.tx_start), 32'd0);
        @(negedge clk);
        chk("busy/tx_start_next", 32'(bus.tx_start), 32'd1);
        chk("busy/tx_data", 32'(bus.tx_data), 32'h4B);
        chk("busy/cpu_hold", 32'(bus.cpu_hold), 32'd0);
        repeat (3) @(negedge clk);
        chk("busy/tx_count", 32'(n_tx), 32'd1);
        chk("busy/start_during_busy", 32'(n_txbusy), 32'd0);

        // Failed load followed by a good one without reset.
        do_reset();
        clear_stats();
        send_seq(128'hA5_02_00_13_00_00_00_93_00_10_00_00, 12);
        release_rx();
        wait_tx(200);
        repeat (3) @(negedge clk);
        chk("retry/first_resp", 32'(tx_last), 32'h45);
        chk("retry/first_err", 32'(bus.bl_error), 32'd1);
        chk("retry/first_hold", 32'(bus.cpu_hold), 32'd1);
        clear_stats();
        send(8'hA5);
        release_rx();
        @(negedge clk);
        chk("retry/err_cleared_on_sync", 32'(bus.bl_error), 32'd0);
        send_seq(128'h02_00_13_00_00_00_93_00_10_00_B6, 11);
        release_rx();
        wait_tx(200);
        repeat (3) @(negedge clk);
        chk("retry/second_resp", 32'(tx_last), 32'h4B);
        chk("retry/second_done", 32'(bus.bl_done), 32'd1);
        chk("retry/second_err", 32'(bus.bl_error), 32'd0);
        chk("retry/second_hold", 32'(bus.cpu_hold), 32'd0);
        chk("retry/second_n_we", 32'(n_we), 32'd2);

        // Reset arriving together with the last byte of word 1.
        do_reset();
        clear_stats();
        send_seq(128'hA5_02_00_13_00_00_00_93_00_10, 10);
        @(posedge clk); #1;
        bus.rx_valid = 1'b1; bus.rx_data = 8'h00; reset = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("midreset/n_we", 32'(n_we), 32'd1);
        chk("midreset/w0_data", wlog_data[0], 32'h0000_0013);
        chk("midreset/mem1_untouched", mem[1], 32'd0);
        chk("midreset/no_tx", 32'(n_tx), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_miss);
        $finish;
    end
endmodule
